// File: rtl/axi2to1_rr_arbiter.sv
// axi2to1_rr_arbiter
//  Two AXI3-style masters share one slave port. The read and write paths each arbitrate
//  round-robin on their own and allow one outstanding transaction per path. A sticky
//  timeout flag reports a slave that leaves a path busy for too long.
// Ports
//  aclk, aresetn            clock; synchronous active-low reset
//  s_ar*/s_r*/s_aw*/s_w*/s_b*  master side. Per-master fields are packed 2x, with master i
//                           in slice i. R and B payloads are shared by both masters.
//  m_ar*/m_r*/m_aw*/m_w*/m_b*  slave side, single width. lock/cache/prot are tied to 0.
//  timeout                  sticky: a path stayed outside IDLE for TIMEOUT cycles
module axi2to1_rr_arbiter #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
)(
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [1:0]                s_arvalid,
  output logic [1:0]                s_arready,
  input  logic [2*ID_W-1:0]         s_arid,
  input  logic [2*ADDR_W-1:0]       s_araddr,
  input  logic [15:0]               s_arlen,
  input  logic [5:0]                s_arsize,
  input  logic [3:0]                s_arburst,
  output logic [1:0]                s_rvalid,
  input  logic [1:0]                s_rready,
  output logic [ID_W-1:0]           s_rid,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  input  logic [1:0]                s_awvalid,
  output logic [1:0]                s_awready,
  input  logic [2*ID_W-1:0]         s_awid,
  input  logic [2*ADDR_W-1:0]       s_awaddr,
  input  logic [15:0]               s_awlen,
  input  logic [5:0]                s_awsize,
  input  logic [3:0]                s_awburst,
  input  logic [1:0]                s_wvalid,
  output logic [1:0]                s_wready,
  input  logic [2*ID_W-1:0]         s_wid,
  input  logic [2*DATA_W-1:0]       s_wdata,
  input  logic [2*(DATA_W/8)-1:0]   s_wstrb,
  input  logic [1:0]                s_wlast,
  output logic [1:0]                s_bvalid,
  input  logic [1:0]                s_bready,
  output logic [ID_W-1:0]           s_bid,
  output logic [1:0]                s_bresp,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ID_W-1:0]           m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic [1:0]                m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ID_W-1:0]           m_awid,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic [1:0]                m_awlock,
  output logic [3:0]                m_awcache,
  output logic [2:0]                m_awprot,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [ID_W-1:0]           m_wid,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  output logic                      m_wlast,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [ID_W-1:0]           m_bid,
  input  logic [1:0]                m_bresp,
  output logic                      timeout
);
  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_st_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_st_t;

  // ---------------- read path ----------------
  rd_st_t              r_rd_st, w_rd_nxt;
  logic                r_rd_g, r_rd_last;
  logic [ID_W-1:0]     r_arid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic [1:0]          r_arburst;
  logic [CW-1:0]       r_rd_cnt;
  logic                w_ar_win, w_ar_take, w_rd_done, w_rd_hit;

  // On a tie the master that did not win last time gets the grant.
  assign w_ar_win  = (&s_arvalid) ? ~r_rd_last : s_arvalid[1];
  assign w_ar_take = aresetn && (r_rd_st == RD_IDLE) && (|s_arvalid);
  assign w_rd_done = (r_rd_st == RD_R) && m_rvalid && s_rready[r_rd_g] && m_rlast;

  always_comb begin
    w_rd_nxt  = r_rd_st;
    s_arready = 2'b00;
    s_rvalid  = 2'b00;
    m_rready  = 1'b0;
    m_arvalid = 1'b0;
    case (r_rd_st)
      RD_IDLE: if (w_ar_take) begin
        s_arready[w_ar_win] = 1'b1;
        w_rd_nxt = RD_AR;
      end
      RD_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_rd_nxt = RD_R;
      end
      RD_R: begin
        s_rvalid[r_rd_g] = m_rvalid;
        m_rready = s_rready[r_rd_g];
        if (w_rd_done) w_rd_nxt = RD_IDLE;
      end
      default: w_rd_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_st   <= RD_IDLE;
      r_rd_g    <= 1'b0;
      r_rd_last <= 1'b1;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else begin
      r_rd_st <= w_rd_nxt;
      if (w_ar_take) begin
        r_rd_g    <= w_ar_win;
        r_arid    <= s_arid[w_ar_win*ID_W +: ID_W];
        r_araddr  <= s_araddr[w_ar_win*ADDR_W +: ADDR_W];
        r_arlen   <= s_arlen[w_ar_win*8 +: 8];
        r_arsize  <= s_arsize[w_ar_win*3 +: 3];
        r_arburst <= s_arburst[w_ar_win*2 +: 2];
      end
      if (w_rd_done) r_rd_last <= r_rd_g;
    end
  end

  assign m_arid    = r_arid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arburst = r_arburst;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign s_rid     = m_rid;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;

  // ---------------- write path ----------------
  wr_st_t              r_wr_st, w_wr_nxt;
  logic                r_wr_g, r_wr_last;
  logic [ID_W-1:0]     r_awid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [7:0]          r_awlen;
  logic [2:0]          r_awsize;
  logic [1:0]          r_awburst;
  logic [CW-1:0]       r_wr_cnt;
  logic                w_aw_win, w_aw_take, w_wr_done, w_wr_hit;

  assign w_aw_win  = (&s_awvalid) ? ~r_wr_last : s_awvalid[1];
  assign w_aw_take = aresetn && (r_wr_st == WR_IDLE) && (|s_awvalid);
  assign w_wr_done = (r_wr_st == WR_B) && m_bvalid && s_bready[r_wr_g];

  always_comb begin
    w_wr_nxt  = r_wr_st;
    s_awready = 2'b00;
    s_wready  = 2'b00;
    s_bvalid  = 2'b00;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    case (r_wr_st)
      WR_IDLE: if (w_aw_take) begin
        s_awready[w_aw_win] = 1'b1;
        w_wr_nxt = WR_AW;
      end
      WR_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) w_wr_nxt = WR_W;
      end
      // W beats are only forwarded once the address has been accepted.
      WR_W: begin
        m_wvalid = s_wvalid[r_wr_g];
        s_wready[r_wr_g] = m_wready;
        if (s_wvalid[r_wr_g] && m_wready && s_wlast[r_wr_g]) w_wr_nxt = WR_B;
      end
      WR_B: begin
        s_bvalid[r_wr_g] = m_bvalid;
        m_bready = s_bready[r_wr_g];
        if (w_wr_done) w_wr_nxt = WR_IDLE;
      end
      default: w_wr_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_st   <= WR_IDLE;
      r_wr_g    <= 1'b0;
      r_wr_last <= 1'b1;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
    end else begin
      r_wr_st <= w_wr_nxt;
      if (w_aw_take) begin
        r_wr_g    <= w_aw_win;
        r_awid    <= s_awid[w_aw_win*ID_W +: ID_W];
        r_awaddr  <= s_awaddr[w_aw_win*ADDR_W +: ADDR_W];
        r_awlen   <= s_awlen[w_aw_win*8 +: 8];
        r_awsize  <= s_awsize[w_aw_win*3 +: 3];
        r_awburst <= s_awburst[w_aw_win*2 +: 2];
      end
      if (w_wr_done) r_wr_last <= r_wr_g;
    end
  end

  assign m_awid    = r_awid;
  assign m_awaddr  = r_awaddr;
  assign m_awlen   = r_awlen;
  assign m_awsize  = r_awsize;
  assign m_awburst = r_awburst;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;
  assign m_wid     = s_wid[r_wr_g*ID_W +: ID_W];
  assign m_wdata   = s_wdata[r_wr_g*DATA_W +: DATA_W];
  assign m_wstrb   = s_wstrb[r_wr_g*SW +: SW];
  assign m_wlast   = s_wlast[r_wr_g];
  assign s_bid     = m_bid;
  assign s_bresp   = m_bresp;

  // ---------------- timeout ----------------
  // The counters hold the number of busy cycles completed so far. The flag sets on the
  // edge that would bring a counter to TIMEOUT. The counters saturate there, so they
  // cannot wrap. A TIMEOUT of 0 keeps both counters at zero and the flag clear.
  assign w_rd_hit = (TIMEOUT != 0) && (r_rd_st != RD_IDLE) && (r_rd_cnt == TO_M1);
  assign w_wr_hit = (TIMEOUT != 0) && (r_wr_st != WR_IDLE) && (r_wr_cnt == TO_M1);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (r_rd_st == RD_IDLE)     r_rd_cnt <= '0;
      else if (r_rd_cnt != TO_LIM) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (r_wr_st == WR_IDLE)     r_wr_cnt <= '0;
      else if (r_wr_cnt != TO_LIM) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_rd_hit || w_wr_hit)   timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi2to1_rr_arbiter.sv
module tb_axi2to1_rr_arbiter;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32;
  logic aclk, aresetn;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_rresp;
  logic [2*ID_W-1:0] s_arid, s_awid, s_wid;
  logic [2*ADDR_W-1:0] s_araddr, s_awaddr;
  logic [15:0] s_arlen, s_awlen;
  logic [5:0] s_arsize, s_awsize;
  logic [3:0] s_arburst, s_awburst;
  logic [ID_W-1:0] s_rid, s_bid;
  logic [DATA_W-1:0] s_rdata;
  logic s_rlast;
  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready, s_bresp;
  logic [2*DATA_W-1:0] s_wdata;
  logic [7:0] s_wstrb;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [ID_W-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [ADDR_W-1:0] m_araddr, m_awaddr;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0] m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
  logic [3:0] m_arcache, m_awcache, m_wstrb;
  logic [DATA_W-1:0] m_rdata, m_wdata;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready, timeout;
  int nvec = 0, nerr = 0;

  axi2to1_rr_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .timeout(timeout));

  initial begin aclk = 0; forever #5 aclk = ~aclk; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Inputs change 1 time unit after each rising edge. Checks run 1 unit after that.
  task automatic step; @(posedge aclk); #1; endtask

  task automatic clear_inputs;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0; s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0;
    s_awburst = 0; s_wvalid = 0; s_wid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    s_bready = 0; m_arready = 0; m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rresp = 0;
    m_rlast = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = 0; m_bresp = 0;
  endtask

  task automatic do_reset;
    aresetn = 0; clear_inputs(); step(); step(); aresetn = 1;
  endtask

  task automatic test_reset;
    aresetn = 0; clear_inputs(); s_arvalid = 2'b11; s_awvalid = 2'b11; step(); step(); #1;
    nvec++; if (s_arready !== 2'b00 || s_awready !== 2'b00) begin nerr++; $display("FAIL rst_ready got ar=%b aw=%b exp 00/00", s_arready, s_awready); end
    nvec++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0 || s_rvalid !== 2'b0 || s_bvalid !== 2'b0 || s_wready !== 2'b0) begin nerr++; $display("FAIL rst_valids got %b exp 0", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s_rvalid, s_bvalid, s_wready}); end
    nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL rst_timeout got %b exp 0", timeout); end
    aresetn = 1; clear_inputs();
  endtask

  task automatic test_write_m0;
    do_reset();
    s_awvalid = 2'b01; s_awid = 8'h03; s_awaddr = {32'h0, 32'h1000_0000};
    s_wvalid = 2'b01; s_wdata = 64'h0; s_wlast = 2'b01; s_wstrb = 8'h0F; s_wid = 8'h03; m_wready = 1; #1;
    nvec++; if (s_awready !== 2'b01) begin nerr++; $display("FAIL wr_awready got %b exp 01", s_awready); end
    nvec++; if (s_wready !== 2'b00) begin nerr++; $display("FAIL wr_w_held got %b exp 00", s_wready); end
    step(); s_awvalid = 0; m_awready = 1; #1;
    nvec++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h1000_0000 || m_awid !== 4'h3) begin nerr++; $display("FAIL wr_maw got v=%b a=%h id=%h exp 1/10000000/3", m_awvalid, m_awaddr, m_awid); end
    nvec++; if (m_wvalid !== 1'b0) begin nerr++; $display("FAIL wr_w_before_aw got %b exp 0", m_wvalid); end
    step(); m_awready = 0; #1;
    nvec++; if (m_wvalid !== 1'b1 || m_wdata !== 32'h0 || m_wlast !== 1'b1 || m_wstrb !== 4'hF || s_wready !== 2'b01) begin nerr++; $display("FAIL wr_w got v=%b d=%h l=%b s=%h rdy=%b", m_wvalid, m_wdata, m_wlast, m_wstrb, s_wready); end
    step(); s_wvalid = 0; m_bvalid = 1; m_bid = 4'h3; m_bresp = 2'b00; s_bready = 2'b01; #1;
    nvec++; if (s_bvalid !== 2'b01 || s_bresp !== 2'b00 || s_bid !== 4'h3 || m_bready !== 1'b1) begin nerr++; $display("FAIL wr_b got bv=%b resp=%b id=%h br=%b exp 01/00/3/1", s_bvalid, s_bresp, s_bid, m_bready); end
    step(); m_bvalid = 0; #1;
    nvec++; if (s_bvalid !== 2'b00) begin nerr++; $display("FAIL wr_b_done got %b exp 00", s_bvalid); end
  endtask

  task automatic test_tie_first;
    do_reset();
    s_arvalid = 2'b11; s_arid = 8'h21; s_araddr = {32'hBBBB_0000, 32'hAAAA_0000}; s_rready = 2'b11; #1;
    nvec++; if (s_arready !== 2'b01) begin nerr++; $display("FAIL tie_first got %b exp 01", s_arready); end
    step(); s_arvalid = 2'b10; m_arready = 1; #1;
    nvec++; if (m_arvalid !== 1'b1 || m_araddr !== 32'hAAAA_0000 || m_arid !== 4'h1 || s_arready !== 2'b00) begin nerr++; $display("FAIL tie_mar got v=%b a=%h id=%h rdy=%b", m_arvalid, m_araddr, m_arid, s_arready); end
    step(); m_arready = 0; m_rvalid = 1; m_rdata = 32'hD0; m_rlast = 0; #1;
    nvec++; if (s_rvalid !== 2'b01 || s_rdata !== 32'hD0 || s_arready !== 2'b00) begin nerr++; $display("FAIL tie_beat0 got rv=%b d=%h ar=%b", s_rvalid, s_rdata, s_arready); end
    step(); m_rdata = 32'hD1; m_rlast = 1; #1;
    nvec++; if (s_rvalid !== 2'b01 || s_rlast !== 1'b1) begin nerr++; $display("FAIL tie_beat1 got rv=%b l=%b", s_rvalid, s_rlast); end
    step(); m_rvalid = 0; m_rlast = 0; #1;
    nvec++; if (s_arready !== 2'b10) begin nerr++; $display("FAIL tie_m1_grant got %b exp 10", s_arready); end
    step(); s_arvalid = 0; m_arready = 1; #1;
    nvec++; if (m_araddr !== 32'hBBBB_0000 || m_arid !== 4'h2) begin nerr++; $display("FAIL tie_m1_ar got a=%h id=%h", m_araddr, m_arid); end
    step(); m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = 32'hE0; #1;
    nvec++; if (s_rvalid !== 2'b10 || s_rdata !== 32'hE0) begin nerr++; $display("FAIL tie_m1_r got rv=%b d=%h", s_rvalid, s_rdata); end
  endtask

  task automatic test_alternate;
    logic [1:0] exp_g;
    do_reset();
    s_arvalid = 2'b11; s_arid = 8'h65; m_arready = 1; m_rvalid = 1; m_rlast = 1; s_rready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10; #1;
      nvec++; if (s_arready !== exp_g) begin nerr++; $display("FAIL alt_grant%0d got %b exp %b", i, s_arready, exp_g); end
      step(); #1;
      nvec++; if (m_arid !== ((i % 2 == 0) ? 4'h5 : 4'h6)) begin nerr++; $display("FAIL alt_id%0d got %h", i, m_arid); end
      step(); #1;
      nvec++; if (s_rvalid !== exp_g) begin nerr++; $display("FAIL alt_r%0d got %b exp %b", i, s_rvalid, exp_g); end
      step();
    end
  endtask

  task automatic test_backpressure;
    logic [5:0] pat;
    int b;
    pat = 6'b110011; b = 0;
    do_reset();
    s_arvalid = 2'b10; s_arlen = 16'h0300; s_arid = 8'h70; #1;
    nvec++; if (s_arready !== 2'b10) begin nerr++; $display("FAIL bp_grant got %b exp 10", s_arready); end
    step(); s_arvalid = 0; m_arready = 1; #1;
    nvec++; if (m_arlen !== 8'd3 || m_arid !== 4'h7) begin nerr++; $display("FAIL bp_arlen got len=%0d id=%h", m_arlen, m_arid); end
    step(); m_arready = 0;
    for (int k = 0; k < 6; k++) begin
      m_rvalid = 1; m_rdata = 32'hA0 + b; m_rlast = (b == 3); s_rready = pat[k] ? 2'b10 : 2'b00; #1;
      nvec++; if (m_rready !== pat[k] || s_rvalid !== 2'b10 || s_rdata !== 32'hA0 + b || s_rlast !== (b == 3)) begin nerr++; $display("FAIL bp_cyc%0d got rr=%b rv=%b d=%h l=%b", k, m_rready, s_rvalid, s_rdata, s_rlast); end
      step(); if (pat[k]) b++;
    end
    s_arvalid = 2'b01; #1;
    nvec++; if (s_arready !== 2'b01 || s_rvalid !== 2'b00) begin nerr++; $display("FAIL bp_idle got ar=%b rv=%b exp 01/00", s_arready, s_rvalid); end
  endtask

  task automatic test_timeout;
    do_reset();
    s_awvalid = 2'b01; step(); // leaves IDLE on this edge
    s_awvalid = 0; m_awready = 1; step();
    m_awready = 0; s_wvalid = 2'b01; s_wlast = 2'b01; m_wready = 1; step();
    s_wvalid = 0; m_wready = 0;
    for (int e = 3; e <= 15; e++) step();
    nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL to_early got %b exp 0", timeout); end
    step();
    nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL to_set got %b exp 1", timeout); end
    for (int e = 0; e < 5; e++) step();
    nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL to_sticky got %b exp 1", timeout); end
    aresetn = 0; step(); aresetn = 1; #1;
    nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL to_clear got %b exp 0", timeout); end
    s_awvalid = 2'b01; #1;
    nvec++; if (s_awready !== 2'b01 || s_bvalid !== 2'b00) begin nerr++; $display("FAIL to_idle got aw=%b bv=%b", s_awready, s_bvalid); end
  endtask

  task automatic test_concurrent;
    do_reset();
    s_awvalid = 2'b01; s_awaddr = {32'h0, 32'h0000_5000};
    s_arvalid = 2'b10; s_araddr = {32'h0000_6000, 32'h0}; #1;
    nvec++; if (s_awready !== 2'b01 || s_arready !== 2'b10) begin nerr++; $display("FAIL cc_grant got aw=%b ar=%b", s_awready, s_arready); end
    step(); s_awvalid = 0; s_arvalid = 0; m_awready = 1; m_arready = 1; #1;
    nvec++; if (m_awvalid !== 1'b1 || m_arvalid !== 1'b1 || m_awaddr !== 32'h5000 || m_araddr !== 32'h6000) begin nerr++; $display("FAIL cc_addr got awv=%b arv=%b aw=%h ar=%h", m_awvalid, m_arvalid, m_awaddr, m_araddr); end
    step(); m_awready = 0; m_arready = 0;
    m_rvalid = 1; m_rlast = 1; m_rdata = 32'h1234; s_rready = 2'b11;
    s_wvalid = 2'b11; s_wdata = {32'hBEEF_0001, 32'hCAFE_0000}; s_wlast = 2'b11; m_wready = 1; #1;
    nvec++; if (m_wdata !== 32'hCAFE_0000 || s_wready !== 2'b01 || s_rvalid !== 2'b10 || s_rdata !== 32'h1234) begin nerr++; $display("FAIL cc_data got wd=%h wr=%b rv=%b rd=%h", m_wdata, s_wready, s_rvalid, s_rdata); end
    step(); m_rvalid = 0; s_wvalid = 0; m_bvalid = 1; m_bid = 4'h9; s_bready = 2'b11; #1;
    nvec++; if (s_bvalid !== 2'b01 || s_bid !== 4'h9 || s_rvalid !== 2'b00) begin nerr++; $display("FAIL cc_b got bv=%b id=%h rv=%b", s_bvalid, s_bid, s_rvalid); end
    step(); m_bvalid = 0; #1;
    nvec++; if (s_bvalid !== 2'b00) begin nerr++; $display("FAIL cc_done got %b exp 00", s_bvalid); end
  endtask

  initial begin
    aresetn = 0; clear_inputs();
    test_reset();
    test_write_m0();
    test_tie_first();
    test_alternate();
    test_backpressure();
    test_timeout();
    test_concurrent();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
